// File: rtl/e_md_sched.sv
// e_md_sched: E-stage multiply/divide scheduler.
//
// Sits between the D/E pipeline register and the E-stage HI/LO unit. It gates
// the E-stage opcode and operands into the unit and stalls HI/LO-class
// instructions in D while an operation is starting or running. It also keeps a
// shadow countdown of the unit's busy period and raises a sticky error flag if
// that countdown ever disagrees with the unit's busy output.
//
// Optional feature macro: MD_PERF_EN adds the md_stall_cnt / md_issue_cnt
// performance counters.
//
// Parameters:
//   MUL_CYC      busy cycles after issue for mult/multu
//   DIV_CYC      busy cycles after issue for div/divu
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   E_HILO_Op    opcode from D/E (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 illegal)
//   E_D1, E_D2   forwarded rs/rt values in E
//   D_is_hilo    D-stage instruction is a HI/LO-class op (1-8)
//   E_flush      E-stage instruction cancelled this cycle
//   HILO_busy    busy flag from the HI/LO unit
//   HILO_Op      gated opcode to the unit
//   HILO_D1/D2   operands to the unit
//   md_stall     stall D/F and insert a bubble into D/E
//   sched_err    sticky protocol / shadow-mismatch flag
//   md_stall_cnt cycles with md_stall=1 (MD_PERF_EN only)
//   md_issue_cnt number of issued mult/div ops (MD_PERF_EN only)
module e_md_sched #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_HILO_Op,
  input  logic [31:0] E_D1,
  input  logic [31:0] E_D2,
  input  logic        D_is_hilo,
  input  logic        E_flush,
  input  logic        HILO_busy,
  output logic [3:0]  HILO_Op,
  output logic [31:0] HILO_D1,
  output logic [31:0] HILO_D2,
  output logic        md_stall,
  output logic        sched_err
`ifdef MD_PERF_EN
  ,
  output logic [31:0] md_stall_cnt,
  output logic [31:0] md_issue_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MUL_LD = 4'(MUL_CYC);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       run;
  logic       op_md;
  logic       op_ill;
  logic       issue;
  logic       err_set;

  // Countdown load value for an issued op: mult/multu vs div/divu.
  function automatic logic [3:0] busy_len(input logic [3:0] op);
    return (op <= 4'd2) ? MUL_LD : DIV_LD;
  endfunction

  assign HILO_D1 = E_D1;
  assign HILO_D2 = E_D2;

  always_comb begin
    run     = (state == RUN);
    op_md   = (E_HILO_Op != 4'd0) && (E_HILO_Op <= 4'd8);
    op_ill  = (E_HILO_Op >= 4'd9);

    // A legal op reaching E during RUN means the stall failed; keep it out of
    // the unit so the running operation is not corrupted.
    HILO_Op = E_HILO_Op;
    if (reset || E_flush || op_ill || (op_md && run))
      HILO_Op = 4'd0;

    issue    = (HILO_Op != 4'd0) && (HILO_Op <= 4'd4);

    // Purely combinational so an op starting in E blocks D the same cycle.
    md_stall = !reset && D_is_hilo && (issue || run || HILO_busy);

    err_set  = (run != HILO_busy) || (op_ill && !E_flush) || (op_md && run);

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = RUN;
          cnt_nxt   = busy_len(HILO_Op);
        end
      end
      RUN: begin
        // E_flush does not abort: the unit finishes regardless.
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sched_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sched_err <= sched_err | err_set;
    end
  end

`ifdef MD_PERF_EN
  // Free-running counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_stall_cnt <= 32'd0;
      md_issue_cnt <= 32'd0;
    end else begin
      if (md_stall) md_stall_cnt <= md_stall_cnt + 32'd1;
      if (issue)    md_issue_cnt <= md_issue_cnt + 32'd1;
    end
  end
`endif

endmodule
